rob_multiport: RTL and testbench



---
 rtl/rob_pkg.sv | 15 +
 rtl/rob_entry.sv | 46 ++++
 rtl/rob_multiport.sv | 181 ++++++++++++++++++
 tb/tb_rob_multiport.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared definitions for the multi-port reorder buffer: entry state encoding
// and a helper that locates a lane's field inside a packed multi-lane bus.
package rob_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'b00,
        INUSE    = 2'b01,
        COMPLETE = 2'b10
    } rob_state_e;

    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/rob_entry.sv
// One reorder-buffer slot: lifecycle state plus destination, result value and
// mispredict flag. Flush dominates; a CDB write only lands on an INUSE slot.
import rob_pkg::*;

module rob_entry #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_BITS   = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  alloc,
    input  logic [REG_BITS-1:0]   alloc_dest,
    input  logic                  cdb_hit,
    input  logic [DATA_WIDTH-1:0] cdb_value,
    input  logic                  cdb_mispred,
    input  logic                  retire_clr,
    input  logic                  flush_clr,
    output rob_state_e            state,
    output logic [REG_BITS-1:0]   dest,
    output logic [DATA_WIDTH-1:0] value,
    output logic                  mispred
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= EMPTY;
            dest    <= '0;
            value   <= '0;
            mispred <= 1'b0;
        end else if (flush_clr) begin
            state <= EMPTY;
        end else if (alloc) begin
            state   <= INUSE;
            dest    <= alloc_dest;
            value   <= '0;
            mispred <= 1'b0;
        end else if (retire_clr) begin
            state <= EMPTY;
        end else if (cdb_hit && state == INUSE) begin
            state   <= COMPLETE;
            value   <= cdb_value;
            mispred <= cdb_mispred;
        end
    end

endmodule

// File: rtl/rob_multiport.sv
// Reorder buffer with multi-lane dispatch/retire, CDB capture with operand
// bypass, occupancy-counted full/empty, retire stall and mispredict flush.
import rob_pkg::*;

module rob_multiport #(
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_BITS   = 5,
    parameter int unsigned DISPATCH_W = 2,
    parameter int unsigned RETIRE_W   = 2,
    parameter int unsigned CDB_W      = 2,
    parameter int unsigned TAG_W      = $clog2(DEPTH)
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic [DISPATCH_W-1:0]              disp_valid,
    input  logic [DISPATCH_W*REG_BITS-1:0]     disp_dest,
    output logic [DISPATCH_W-1:0]              disp_accept,
    output logic [DISPATCH_W*TAG_W-1:0]        disp_tag,
    input  logic [CDB_W-1:0]                   cdb_valid,
    input  logic [CDB_W*TAG_W-1:0]             cdb_tag,
    input  logic [CDB_W*DATA_WIDTH-1:0]        cdb_value,
    input  logic [CDB_W-1:0]                   cdb_mispred,
    input  logic [2*DISPATCH_W*TAG_W-1:0]      rd_tag,
    output logic [2*DISPATCH_W-1:0]            rd_ready,
    output logic [2*DISPATCH_W*DATA_WIDTH-1:0] rd_value,
    input  logic                               ret_stall,
    output logic [RETIRE_W-1:0]                ret_valid,
    output logic [RETIRE_W*REG_BITS-1:0]       ret_dest,
    output logic [RETIRE_W*DATA_WIDTH-1:0]     ret_value,
    output logic                               flush,
    output logic [TAG_W:0]                     count,
    output logic                               full,
    output logic                               empty
);

    typedef logic [TAG_W:0]   cnt_t;
    typedef logic [TAG_W-1:0] tag_t;

    tag_t head, tail;
    tag_t flush_tag;
    cnt_t n_acc, n_ret, free;

    rob_state_e            ent_state   [DEPTH];
    logic [REG_BITS-1:0]   ent_dest    [DEPTH];
    logic [DATA_WIDTH-1:0] ent_value   [DEPTH];
    logic [REG_BITS-1:0]   alloc_dest  [DEPTH];
    logic [DATA_WIDTH-1:0] hit_value   [DEPTH];
    logic [DEPTH-1:0]      ent_mispred, ent_alloc, ent_retire, ent_hit, hit_mispred;

    tag_t ret_idx, acc_idx, rd_idx;
    logic ret_go, acc_go;

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        rob_entry #(
            .DATA_WIDTH(DATA_WIDTH),
            .REG_BITS  (REG_BITS)
        ) u_entry (
            .clock      (clock),
            .reset_n    (reset_n),
            .alloc      (ent_alloc[g]),
            .alloc_dest (alloc_dest[g]),
            .cdb_hit    (ent_hit[g]),
            .cdb_value  (hit_value[g]),
            .cdb_mispred(hit_mispred[g]),
            .retire_clr (ent_retire[g]),
            .flush_clr  (flush),
            .state      (ent_state[g]),
            .dest       (ent_dest[g]),
            .value      (ent_value[g]),
            .mispred    (ent_mispred[g])
        );
    end

    // Retire chain: stops at the first incomplete entry or just after a mispredicted one
    always_comb begin
        ret_valid  = '0;
        ret_dest   = '0;
        ret_value  = '0;
        ent_retire = '0;
        flush      = 1'b0;
        flush_tag  = '0;
        n_ret      = '0;
        ret_go     = !ret_stall;
        ret_idx    = '0;
        for (int unsigned j = 0; j < RETIRE_W; j++) begin
            ret_idx = head + tag_t'(j);
            ret_dest[lane_lsb(j, REG_BITS) +: REG_BITS]     = ent_dest[ret_idx];
            ret_value[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH] = ent_value[ret_idx];
            if (ret_go && ent_state[ret_idx] == COMPLETE) begin
                ret_valid[j]        = 1'b1;
                ent_retire[ret_idx] = 1'b1;
                n_ret               = n_ret + cnt_t'(1);
                if (ent_mispred[ret_idx]) begin
                    flush     = 1'b1;
                    flush_tag = ret_idx;
                    ret_go    = 1'b0;
                end
            end else begin
                ret_go = 1'b0;
            end
        end
    end

    // Free space comes from registered count only, so same-cycle retirements do not help
    always_comb begin
        disp_accept = '0;
        disp_tag    = '0;
        ent_alloc   = '0;
        n_acc       = '0;
        acc_idx     = '0;
        acc_go      = !flush;
        free        = cnt_t'(DEPTH) - count;
        for (int unsigned i = 0; i < DEPTH; i++) alloc_dest[i] = '0;
        for (int unsigned k = 0; k < DISPATCH_W; k++) begin
            acc_idx = tail + tag_t'(k);
            disp_tag[lane_lsb(k, TAG_W) +: TAG_W] = acc_idx;
            acc_go = acc_go && disp_valid[k] && (cnt_t'(k) < free);
            if (acc_go) begin
                disp_accept[k]      = 1'b1;
                ent_alloc[acc_idx]  = 1'b1;
                alloc_dest[acc_idx] = disp_dest[lane_lsb(k, REG_BITS) +: REG_BITS];
                n_acc               = n_acc + cnt_t'(1);
            end
        end
    end

    // Buses scanned high to low so the lowest-indexed matching bus wins
    always_comb begin
        ent_hit     = '0;
        hit_mispred = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            hit_value[i] = '0;
            for (int unsigned b = CDB_W; b > 0; b--) begin
                if (cdb_valid[b-1] && cdb_tag[lane_lsb(b-1, TAG_W) +: TAG_W] == tag_t'(i)) begin
                    ent_hit[i]     = 1'b1;
                    hit_value[i]   = cdb_value[lane_lsb(b-1, DATA_WIDTH) +: DATA_WIDTH];
                    hit_mispred[i] = cdb_mispred[b-1];
                end
            end
        end
    end

    always_comb begin
        rd_ready = '0;
        rd_value = '0;
        rd_idx   = '0;
        for (int unsigned r = 0; r < 2 * DISPATCH_W; r++) begin
            rd_idx      = rd_tag[lane_lsb(r, TAG_W) +: TAG_W];
            rd_ready[r] = (ent_state[rd_idx] == COMPLETE);
            rd_value[lane_lsb(r, DATA_WIDTH) +: DATA_WIDTH] = ent_value[rd_idx];
            for (int unsigned b = CDB_W; b > 0; b--) begin
                if (cdb_valid[b-1] && cdb_tag[lane_lsb(b-1, TAG_W) +: TAG_W] == rd_idx) begin
                    rd_ready[r] = 1'b1;
                    rd_value[lane_lsb(r, DATA_WIDTH) +: DATA_WIDTH] =
                        cdb_value[lane_lsb(b-1, DATA_WIDTH) +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= flush_tag + tag_t'(1);
            tail  <= flush_tag + tag_t'(1);
            count <= '0;
        end else begin
            head  <= head + n_ret[TAG_W-1:0];
            tail  <= tail + n_acc[TAG_W-1:0];
            count <= count + n_acc - n_ret;
        end
    end

    assign full  = (count == cnt_t'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: tb/tb_rob_multiport.sv
// Directed vector bench for rob_multiport at DEPTH = 4: table of hand-computed
// vectors, then a wrap-around stream and an asynchronous mid-stream reset.
module tb_rob_multiport;

    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [1:0]    disp_valid;
    logic [9:0]    disp_dest;
    logic [1:0]    disp_accept;
    logic [3:0]    disp_tag;
    logic [1:0]    cdb_valid;
    logic [3:0]    cdb_tag;
    logic [63:0]   cdb_value;
    logic [1:0]    cdb_mispred;
    logic [7:0]    rd_tag;
    logic [3:0]    rd_ready;
    logic [127:0]  rd_value;
    logic          ret_stall;
    logic [1:0]    ret_valid;
    logic [9:0]    ret_dest;
    logic [63:0]   ret_value;
    logic          flush;
    logic [2:0]    count;
    logic          full;
    logic          empty;

    rob_multiport #(
        .DEPTH     (4),
        .DATA_WIDTH(DW),
        .REG_BITS  (5),
        .DISPATCH_W(2),
        .RETIRE_W  (2),
        .CDB_W     (2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .disp_valid (disp_valid),
        .disp_dest  (disp_dest),
        .disp_accept(disp_accept),
        .disp_tag   (disp_tag),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_value  (cdb_value),
        .cdb_mispred(cdb_mispred),
        .rd_tag     (rd_tag),
        .rd_ready   (rd_ready),
        .rd_value   (rd_value),
        .ret_stall  (ret_stall),
        .ret_valid  (ret_valid),
        .ret_dest   (ret_dest),
        .ret_value  (ret_value),
        .flush      (flush),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  dv;
        logic [9:0]  dd;
        logic [1:0]  cv;
        logic [3:0]  ct;
        logic [31:0] cval0;
        logic [31:0] cval1;
        logic [1:0]  cmis;
        logic [1:0]  rt0;
        logic        stall;
        logic [1:0]  e_acc;
        logic [3:0]  e_tag;
        logic [1:0]  e_rv;
        logic [31:0] e_rval0;
        logic [31:0] e_rval1;
        logic        e_fl;
        logic [2:0]  e_cnt;
        logic        e_rdy;
        logic [31:0] e_rdv;
    } vec_t;

    vec_t vec [15];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
            nerr++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //          dv     dd             cv     ct       cval0   cval1   cmis   rt  st | acc    tag      rv     rval0   rval1   fl  cnt rdy rdv
        vec[0]  = '{2'b00, 10'd0,         2'b00, 4'b0000, 32'h0,  32'h0,  2'b00, 2'd0, 0, 2'b00, 4'b0100, 2'b00, 32'h0,  32'h0,  0, 3'd0, 0, 32'h0};
        vec[1]  = '{2'b11, {5'd7, 5'd3},  2'b00, 4'b0000, 32'h0,  32'h0,  2'b00, 2'd0, 0, 2'b11, 4'b0100, 2'b00, 32'h0,  32'h0,  0, 3'd0, 0, 32'h0};
        vec[2]  = '{2'b11, {5'd9, 5'd8},  2'b00, 4'b0000, 32'h0,  32'h0,  2'b00, 2'd0, 0, 2'b11, 4'b1110, 2'b00, 32'h0,  32'h0,  0, 3'd2, 0, 32'h0};
        vec[3]  = '{2'b11, 10'd0,         2'b01, 4'b0010, 32'h55, 32'h0,  2'b00, 2'd2, 0, 2'b00, 4'b0100, 2'b00, 32'h0,  32'h0,  0, 3'd4, 1, 32'h55};
        vec[4]  = '{2'b11, 10'd0,         2'b11, 4'b0001, 32'hAA, 32'hBB, 2'b00, 2'd0, 0, 2'b00, 4'b0100, 2'b00, 32'h0,  32'h0,  0, 3'd4, 1, 32'hBB};
        vec[5]  = '{2'b11, 10'd0,         2'b00, 4'b0000, 32'h0,  32'h0,  2'b00, 2'd2, 0, 2'b00, 4'b0100, 2'b11, 32'hBB, 32'hAA, 0, 3'd4, 1, 32'h55};
        vec[6]  = '{2'b11, {5'd11,5'd10}, 2'b00, 4'b0000, 32'h0,  32'h0,  2'b00, 2'd2, 0, 2'b11, 4'b0100, 2'b01, 32'h55, 32'h0,  0, 3'd2, 1, 32'h55};
        vec[7]  = '{2'b00, 10'd0,         2'b01, 4'b0011, 32'h33, 32'h0,  2'b01, 2'd3, 0, 2'b00, 4'b1110, 2'b00, 32'h0,  32'h0,  0, 3'd3, 1, 32'h33};
        vec[8]  = '{2'b11, 10'd0,         2'b01, 4'b0000, 32'h44, 32'h0,  2'b00, 2'd0, 0, 2'b00, 4'b1110, 2'b01, 32'h33, 32'h0,  1, 3'd3, 1, 32'h44};
        vec[9]  = '{2'b00, 10'd0,         2'b00, 4'b0000, 32'h0,  32'h0,  2'b00, 2'd0, 0, 2'b00, 4'b0100, 2'b00, 32'h0,  32'h0,  0, 3'd0, 0, 32'h0};
        vec[10] = '{2'b01, {5'd0, 5'd5},  2'b00, 4'b0000, 32'h0,  32'h0,  2'b00, 2'd0, 0, 2'b01, 4'b0100, 2'b00, 32'h0,  32'h0,  0, 3'd0, 0, 32'h0};
        vec[11] = '{2'b00, 10'd0,         2'b11, 4'b0000, 32'h77, 32'h99, 2'b01, 2'd0, 0, 2'b00, 4'b1001, 2'b00, 32'h0,  32'h0,  0, 3'd1, 1, 32'h77};
        vec[12] = '{2'b00, 10'd0,         2'b00, 4'b0000, 32'h0,  32'h0,  2'b00, 2'd0, 1, 2'b00, 4'b1001, 2'b00, 32'h0,  32'h0,  0, 3'd1, 1, 32'h77};
        vec[13] = '{2'b00, 10'd0,         2'b00, 4'b0000, 32'h0,  32'h0,  2'b00, 2'd0, 0, 2'b00, 4'b1001, 2'b01, 32'h77, 32'h0,  1, 3'd1, 1, 32'h77};
        vec[14] = '{2'b10, 10'd0,         2'b00, 4'b0000, 32'h0,  32'h0,  2'b00, 2'd1, 0, 2'b00, 4'b1001, 2'b00, 32'h0,  32'h0,  0, 3'd0, 0, 32'h0};

        reset_n     = 1'b0;
        disp_valid  = '0;
        disp_dest   = '0;
        cdb_valid   = '0;
        cdb_tag     = '0;
        cdb_value   = '0;
        cdb_mispred = '0;
        rd_tag      = '0;
        ret_stall   = 1'b0;
        #12 reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            disp_valid  = vec[i].dv;
            disp_dest   = vec[i].dd;
            cdb_valid   = vec[i].cv;
            cdb_tag     = vec[i].ct;
            cdb_value   = {vec[i].cval1, vec[i].cval0};
            cdb_mispred = vec[i].cmis;
            rd_tag      = {6'd0, vec[i].rt0};
            ret_stall   = vec[i].stall;
            #1;
            nvec++;
            chk($sformatf("v%0d disp_accept", i), 64'(disp_accept), 64'(vec[i].e_acc));
            chk($sformatf("v%0d disp_tag", i),    64'(disp_tag),    64'(vec[i].e_tag));
            chk($sformatf("v%0d ret_valid", i),   64'(ret_valid),   64'(vec[i].e_rv));
            chk($sformatf("v%0d flush", i),       64'(flush),       64'(vec[i].e_fl));
            chk($sformatf("v%0d count", i),       64'(count),       64'(vec[i].e_cnt));
            chk($sformatf("v%0d empty", i),       64'(empty),       64'(vec[i].e_cnt == 3'd0));
            chk($sformatf("v%0d full", i),        64'(full),        64'(vec[i].e_cnt == 3'd4));
            chk($sformatf("v%0d rd_ready0", i),   64'(rd_ready[0]), 64'(vec[i].e_rdy));
            chk($sformatf("v%0d rd_value0", i),   64'(rd_value[31:0]), 64'(vec[i].e_rdv));
            if (vec[i].e_rv[0])
                chk($sformatf("v%0d ret_value0", i), 64'(ret_value[31:0]), 64'(vec[i].e_rval0));
            if (vec[i].e_rv[1])
                chk($sformatf("v%0d ret_value1", i), 64'(ret_value[63:32]), 64'(vec[i].e_rval1));
        end

        // Wrap stream: head = tail = 1, dispatch one per cycle, complete it next cycle, retire after
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            disp_valid  = 2'b01;
            disp_dest   = {5'd0, 5'(i)};
            cdb_valid   = (i >= 1) ? 2'b01 : 2'b00;
            cdb_tag     = {2'd0, 2'(i % 4)};
            cdb_value   = {32'h0, 32'(32'h100 + i - 1)};
            cdb_mispred = '0;
            rd_tag      = '0;
            ret_stall   = 1'b0;
            #1;
            nvec++;
            chk($sformatf("wrap%0d tag0", i),   64'(disp_tag[1:0]), 64'((1 + i) % 4));
            chk($sformatf("wrap%0d accept", i), 64'(disp_accept),   64'(2'b01));
            chk($sformatf("wrap%0d count", i),  64'(count),         64'((i == 0) ? 0 : (i == 1) ? 1 : 2));
            chk($sformatf("wrap%0d ret_valid", i), 64'(ret_valid),  64'((i >= 2) ? 2'b01 : 2'b00));
            if (i >= 2) begin
                chk($sformatf("wrap%0d ret_value0", i), 64'(ret_value[31:0]), 64'(32'h100 + i - 2));
                chk($sformatf("wrap%0d ret_dest0", i),  64'(ret_dest[4:0]),   64'(i - 2));
            end
        end

        // Asynchronous reset between clock edges
        @(negedge clock);
        disp_valid = 2'b11;
        cdb_valid  = '0;
        #1 reset_n = 1'b0;
        #1;
        nvec++;
        chk("async count",       64'(count),       64'(0));
        chk("async empty",       64'(empty),       64'(1));
        chk("async full",        64'(full),        64'(0));
        chk("async ret_valid",   64'(ret_valid),   64'(0));
        chk("async flush",       64'(flush),       64'(0));
        chk("async disp_accept", 64'(disp_accept), 64'(2'b11));
        chk("async disp_tag",    64'(disp_tag),    64'(4'b0100));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
